// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants; UART_TX_PARITY_EN adds the PARITY state
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Line levels for the idle, start and stop conditions
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  // Even parity bit: 1 when the byte holds an odd number of ones
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop, full/empty and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Full and empty come straight from the registered count, so a pop in the
  // same cycle never opens the write port of a full FIFO.
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  tx_state_e              state_q, state_d;
  logic [15:0]            baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;
  logic                   baud_done;
  logic [2:0]             next_idx;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_done = (baud_q == '0);
  assign next_idx  = bit_idx_q + 3'd1;
  assign wr_ready  = !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  // Frame sequencer: tx_d is the level of the bit that starts on the next edge,
  // so the line is driven from a flop and each bit lasts exactly CLK_DIV cycles.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_d = baud_done ? BAUD_RELOAD : (baud_q - 16'd1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_data;
          baud_d    = BAUD_RELOAD;
          bit_idx_d = '0;
          state_d   = ST_START;
          tx_d      = LINE_START;
        end
      end

      ST_START: begin
        if (baud_done) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = even_parity(shift_q);
`else
            state_d = ST_STOP;
            tx_d    = LINE_STOP;
`endif
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          tx_d    = LINE_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when a byte is waiting
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_data;
            bit_idx_d = '0;
            state_d   = ST_START;
            tx_d      = LINE_START;
          end else begin
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset forces the line high and abandons any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (parity cases under UART_TX_PARITY_EN)
module tb_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks;
  int n_pass;
  int cyc;
  int last_acc;
  logic [7:0] rx_q[$];
  int         st_q[$];
`ifdef UART_TX_PARITY_EN
  logic       last_par;
`endif

  uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic rx_wait(input int n, inout bit aborted);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst_n) aborted = 1'b1;
    end
  endtask

  // Expected line level per cycle for one frame, bit 0 of the result first
  function automatic logic [63:0] frame_wave(input logic [7:0] d);
    logic [15:0] fb;
    logic [63:0] w;
    fb      = '1;
    fb[0]   = 1'b0;
    fb[8:1] = d;
`ifdef UART_TX_PARITY_EN
    fb[9]   = ^d;
`endif
    w = '0;
    for (int i = 0; i < FRAME_CYC; i++) w[i] = fb[i / CLK_DIV];
    return w;
  endfunction

  // Line decoder: samples mid-bit, aborts on reset, logs bytes and start cycles
  initial begin : rx_decoder
    logic [7:0] data;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        data    = '0;
        aborted = 1'b0;
        st_q.push_back(cyc);
        rx_wait(2, aborted);
        for (int b = 1; b < FRAME_BITS; b++) begin
          rx_wait(CLK_DIV, aborted);
          if (aborted) break;
          if (b <= 8) data[b-1] = tx;
          else if (b == FRAME_BITS - 1) check("rx_stop", 64'(tx), 64'(1));
`ifdef UART_TX_PARITY_EN
          else last_par = tx;
`endif
        end
        if (!aborted) rx_q.push_back(data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] wave;
    logic        busy_last;
    logic        acc_now;
    logic        tx_low;
    int          accepted;
    int          t0;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    wave     = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x55: one-cycle latency, exact bit timing, busy span
    rx_q.delete();
    st_q.delete();
    write_byte(8'h55);
    @(negedge clk);
    check("t1_count", 64'(fifo_count), 64'(1));
    check("t1_tx_pre", 64'(tx), 64'(1));
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      wave[i] = tx;
    end
    busy_last = busy;
    @(negedge clk);
    check("t1_wave", wave, frame_wave(8'h55));
    check("t1_busy_last_bit", 64'(busy_last), 64'(1));
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_rx_n", 64'(rx_q.size()), 64'(1));
    if (rx_q.size() > 0) check("t1_rx", 64'(rx_q[0]), 64'h55);

    // Hold wr_en with 0,1,2..: 5 accepted, then a write while full is dropped
    rx_q.delete();
    st_q.delete();
    accepted = 0;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h00;
    for (int c = 0; c < 12; c++) begin
      acc_now = wr_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        accepted++;
        wr_data = 8'(accepted);
      end
      @(negedge clk);
    end
    check("t2_accepted", 64'(accepted), 64'(5));
    check("t2_count_full", 64'(fifo_count), 64'(4));
    check("t2_wr_ready", 64'(wr_ready), 64'(0));
    wr_data = 8'hEE;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("t6_count_after_drop", 64'(fifo_count), 64'(4));
    wait_idle(6 * FRAME_CYC, "t2");
    check("t2_rx_n", 64'(rx_q.size()), 64'(5));
    for (int k = 0; k < 5 && k < rx_q.size(); k++) check($sformatf("t2_rx%0d", k), 64'(rx_q[k]), 64'(k));
    for (int k = 1; k < 5 && k < st_q.size(); k++)
      check($sformatf("t2_gap%0d", k), 64'(st_q[k] - st_q[k-1]), 64'(FRAME_CYC));

    // Push on the STOP->START pop edge with two bytes queued
    rx_q.delete();
    st_q.delete();
    write_byte(8'hA1);
    t0 = last_acc;
    write_byte(8'hB2);
    write_byte(8'hC3);
    while (cyc < t0 + FRAME_CYC) @(negedge clk);
    check("t3_count_before", 64'(fifo_count), 64'(2));
    wr_en   = 1'b1;
    wr_data = 8'hD4;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("t3_count_after", 64'(fifo_count), 64'(2));
    check("t3_tx_start", 64'(tx), 64'(0));
    wait_idle(6 * FRAME_CYC, "t3");
    check("t3_rx_n", 64'(rx_q.size()), 64'(4));
    if (rx_q.size() == 4) begin
      check("t3_rx0", 64'(rx_q[0]), 64'hA1);
      check("t3_rx1", 64'(rx_q[1]), 64'hB2);
      check("t3_rx2", 64'(rx_q[2]), 64'hC3);
      check("t3_rx3", 64'(rx_q[3]), 64'hD4);
    end

    // Reset during data bit 2 of 0xA3 (a 0) with two bytes queued
    rx_q.delete();
    st_q.delete();
    write_byte(8'hA3);
    t0 = last_acc;
    write_byte(8'h11);
    write_byte(8'h22);
    while (cyc < t0 + 14) @(negedge clk);
    check("t4_tx_pre", 64'(tx), 64'(0));
    check("t4_count_pre", 64'(fifo_count), 64'(2));
    #1;
    rst_n = 1'b0;
    #1;
    check("t4_rst_tx", 64'(tx), 64'(1));
    check("t4_rst_busy", 64'(busy), 64'(0));
    check("t4_rst_count", 64'(fifo_count), 64'(0));
    check("t4_rst_wr_ready", 64'(wr_ready), 64'(1));
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    tx_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    check("t4_no_residual_tx", 64'(tx_low), 64'(0));
    check("t4_no_residual_rx", 64'(rx_q.size()), 64'(0));
    check("t4_busy_after", 64'(busy), 64'(0));

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two
    rx_q.delete();
    st_q.delete();
    write_byte(8'h07);
    wait_idle(3 * FRAME_CYC, "t5a");
    check("t5_par_07", 64'(last_par), 64'(1));
    check("t5_rx_07", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 64'h07);
    write_byte(8'h03);
    wait_idle(3 * FRAME_CYC, "t5b");
    check("t5_par_03", 64'(last_par), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter for the SoC console path. It accepts bytes from the core's store path over a valid/ready write port and buffers them in a small FIFO. Each byte is serialised as an 8N1 frame (optionally 8E1) on a single `tx` line at a fixed clock divisor. It is the transmit end of the console link that the test benches decode to produce pass/fail text.

## Interface

Parameters:
- `CLK_DIV`, default 16: clock cycles per bit; legal range 2..65535.
- `FIFO_DEPTH`, default 4: byte FIFO depth; must be a power of two, minimum 2.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `wr_en`, input, 1: write request.
- `wr_data`, input, 8: byte to transmit.
- `wr_ready`, output, 1: FIFO can accept a byte (not full).
- `tx`, output, 1: serial line; idles high.
- `busy`, output, 1: FIFO non-empty or a frame in progress.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: bytes held in the FIFO, excluding the frame in flight.

## Operation

- **Write handshake:** a byte is accepted on an edge where `wr_en && wr_ready`. `wr_en` while `wr_ready` is low is ignored: data dropped, no state change.
- **Byte order:** FIFO order is strict; bytes go out in acceptance order.
- **FSM states:** IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- **IDLE:** `tx`=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLK_DIV-1, go to START.
- **Baud counter:** counts down from CLK_DIV-1 to 0. At 0 the FSM advances and the counter reloads, so every bit lasts exactly CLK_DIV cycles.
- **START:** `tx`=0.
- **DATA:** bits 0..7, LSB first. A 3-bit index selects the bit; after bit 7 go to PARITY or STOP.
- **STOP:** `tx`=1. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- **Simultaneous push and pop:** when the FIFO is non-full, both happen in the same cycle, `fifo_count` is unchanged, and no data is lost. When the FIFO is full, `wr_ready` is low, so a same-cycle pop does not enable the write.
- **Capacity:** capacity seen by the writer is FIFO_DEPTH bytes plus the one in the shift register.
- **`busy`:** `busy` = (state != IDLE) || (fifo_count != 0).
- **Reset values:** `tx`=1, `busy`=0, `wr_ready`=1, `fifo_count`=0, FSM=IDLE, FIFO pointers=0.
- **Reset mid-operation:** reset mid-frame aborts the frame and flushes the FIFO. `tx` goes high asynchronously with the `rst_n` fall.

## Timing

- **Latency:** byte accepted at edge N into an empty FIFO while IDLE gives `tx` low after edge N+1. `tx` is registered, with no combinational path from inputs.
- **Frame length:** 10*CLK_DIV cycles without parity, 11*CLK_DIV with parity.
- **`wr_ready`:** registered-equivalent: it is derived from the registered count, never from `wr_en`.
- **`fifo_count`:** updates on the edge following the push or pop.

## Configuration

- **`UART_TX_PARITY_EN` defined:** PARITY state inserted after bit 7. It drives even parity (XOR of the 8 data bits) for CLK_DIV cycles. Frame becomes 8E1.
- **`UART_TX_PARITY_EN` undefined:** PARITY state and its logic are absent. Frame is 8N1.

## Structure

- **Shared package `uart_pkg`:**
  - FSM state enum.
  - `UART_DATA_W` = 8.
  - Idle/start/stop line-level constants.
  - A parity function (used only when the macro is defined).
- **Sub-module `sync_fifo`:**
  - Parameters: width and depth.
  - Signals: push/pop, full/empty, count.
  - Reusable by the future `uart_rx`.
- **Top level:** contains the baud counter, bit index, shift register and FSM.

## Test plan

1. CLK_DIV=4, write 0x55 once. `tx` falls one cycle after acceptance and carries 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles. `busy` drops after 40 cycles.
2. CLK_DIV=4, FIFO_DEPTH=4, hold `wr_en` with data 0x00,0x01,... Exactly 5 bytes are accepted before `wr_ready` deasserts. All 5 are transmitted in order, back-to-back, over 200 cycles with no idle bit between frames.
3. Push while the FSM pops (FIFO count 2, write on the STOP→START edge). `fifo_count` stays 2 and no byte is lost or duplicated.
4. Assert `rst_n`=0 mid-DATA of 0xA3 with 2 bytes queued. `tx`=1 immediately; `busy`=0, `fifo_count`=0, `wr_ready`=1. After release, no residual frame is emitted.
5. With `UART_TX_PARITY_EN`, write 0x07. The parity bit is 1 and the frame is 44 cycles at CLK_DIV=4. Writing 0x03 gives parity bit 0.
6. Write with `wr_ready` low (FIFO full). The byte is dropped and the output sequence contains only the previously accepted bytes.
